// File: rtl/sram_like_pkg.sv
// Shared constants and the response record for the sram-like responder.
//   DATA_W : data bus width
//   STRB_W : number of byte-lane write enables
//   resp_t : one response slot {valid, rdata}
package sram_like_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-latency shift register of response records.
// A record presented on rec_i at a clock edge appears on rec_o LATENCY-1 edges later,
// i.e. LATENCY cycles after the cycle in which it was presented.
//   clk   : clock
//   reset : asynchronous active-high reset, empties every stage
//   rec_i : record entering the line
//   rec_o : record leaving the line (registered)
module resp_delay_line
  import sram_like_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  resp_t rec_i,
  output resp_t rec_o
);

  resp_t [LATENCY-1:0] stage_q;
  resp_t [LATENCY-1:0] stage_d;

  // Next-state: new record into stage 0, everything else shifts up by one.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = rec_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign rec_o = stage_q[LATENCY-1];

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side responder for an sram-like request/response interface.
// Serves requests from an internal word array; every accepted request is answered
// exactly LATENCY cycles later, and at most QDEPTH requests may be outstanding.
//   clk     : clock, all state on rising edge
//   reset   : asynchronous active-high reset (array contents are preserved)
//   req     : request valid
//   wr      : 1 = write, 0 = read
//   wstrb   : byte-lane write enables
//   addr    : byte address, word index = addr[ADDR_W+1:2]
//   wdata   : write data
//   hold    : external backpressure, forces addr_ok low
//   addr_ok : request accepted this cycle when req & addr_ok (combinational)
//   data_ok : one-cycle response pulse (registered)
//   rdata   : read data while data_ok, zero otherwise (registered)
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              hold,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  resp_t             rec_in;
  resp_t             rec_out;
  logic              unused_addr_bits;

  // Only the word-index bits select storage; the rest alias.
  assign word_idx         = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Acceptance depends only on registered occupancy, so a freed slot shows up a cycle later.
  assign addr_ok = ~reset & ~hold & (count_q < CNT_W'(QDEPTH));
  assign accept  = req & addr_ok;

  // Word array with byte-lane writes; deliberately not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read sample: earlier writes are already in the array; write responses carry zero.
  always_comb begin
    rec_in       = '0;
    rec_in.valid = accept;
    if (accept && !wr) begin
      rec_in.rdata = mem_q[word_idx];
    end
  end

  resp_delay_line #(
    .LATENCY (LATENCY)
  ) u_resp_delay_line (
    .clk   (clk),
    .reset (reset),
    .rec_i (rec_in),
    .rec_o (rec_out)
  );

  assign data_ok = rec_out.valid;
  assign rdata   = rec_out.rdata;

  // Outstanding counter: accept and response in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (accept && !rec_out.valid) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && rec_out.valid) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed self-checking bench for sram_like_responder.
// dut2: LATENCY=2, QDEPTH=2; dut1: LATENCY=1, QDEPTH=2. Both share clock and stimulus.
module tb_sram_like_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        hold  = 1'b0;

  logic        aok2, dok2, aok1, dok1;
  logic [31:0] rd2, rd1;

  logic        s_aok2, s_dok2, s_aok1, s_dok1;
  logic [31:0] s_rd2, s_rd1;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A = 32'h1c00_0000;

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
  } vec_t;

  sram_like_responder #(.ADDR_W(14), .LATENCY(2), .QDEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .hold(hold), .addr_ok(aok2), .data_ok(dok2), .rdata(rd2)
  );

  sram_like_responder #(.ADDR_W(14), .LATENCY(1), .QDEPTH(2)) dut1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .hold(hold), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d, input logic h,
                              input logic eaok, input logic edok, input logic [31:0] erd);
    vec_t v;
    v.req = r; v.wr = w; v.strb = s; v.addr = a; v.wdata = d; v.hold = h;
    v.aok = eaok; v.dok = edok; v.rd = erd;
    return v;
  endfunction

  // One clock cycle: drive inputs, sample outputs mid-cycle, return just after the closing edge.
  task automatic cyc(input logic r, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d, input logic h);
    req = r; wr = w; wstrb = s; addr = a; wdata = d; hold = h;
    @(negedge clk);
    s_aok2 = aok2; s_dok2 = dok2; s_rd2 = rd2;
    s_aok1 = aok1; s_dok1 = dok1; s_rd1 = rd1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b1, 1'b0, 4'h0, A, 32'h0, 1'b0);
    checks++; if (s_aok2 !== 1'b0) begin failures++; $display("FAIL reset_aok2 got=%b exp=0", s_aok2); end
    checks++; if (s_dok2 !== 1'b0) begin failures++; $display("FAIL reset_dok2 got=%b exp=0", s_dok2); end
    checks++; if (s_rd2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=0", s_rd2); end
    checks++; if (s_aok1 !== 1'b0) begin failures++; $display("FAIL reset_aok1 got=%b exp=0", s_aok1); end
    checks++; if (s_dok1 !== 1'b0) begin failures++; $display("FAIL reset_dok1 got=%b exp=0", s_dok1); end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (s_aok2 !== 1'b1) begin failures++; $display("FAIL post_reset_aok2 got=%b exp=1", s_aok2); end
    checks++; if (s_dok2 !== 1'b0) begin failures++; $display("FAIL post_reset_dok2 got=%b exp=0", s_dok2); end
  endtask

  // Full write then read of the same word, then a single-lane update and a zero-strobe write.
  task automatic test_write_read();
    vec_t v[16];
    v[0]  = mk(1, 1, 4'hF, A, 32'h1234_5678, 0, 1, 0, 32'h0);
    v[1]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    v[2]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 1, 32'h0);
    v[3]  = mk(1, 0, 4'h0, A, 32'h0,         0, 1, 0, 32'h0);
    v[4]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    v[5]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 1, 32'h1234_5678);
    v[6]  = mk(1, 1, 4'h2, A, 32'h0000_AB00, 0, 1, 0, 32'h0);
    v[7]  = mk(1, 0, 4'h0, A, 32'h0,         0, 1, 0, 32'h0);
    v[8]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 0, 1, 32'h0);
    v[9]  = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 1, 32'h1234_AB78);
    v[10] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    v[11] = mk(1, 1, 4'h0, A, 32'hFFFF_FFFF, 0, 1, 0, 32'h0);
    v[12] = mk(1, 0, 4'h0, A, 32'h0,         0, 1, 0, 32'h0);
    v[13] = mk(0, 0, 4'h0, 0, 32'h0,         0, 0, 1, 32'h0);
    v[14] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 1, 32'h1234_AB78);
    v[15] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    foreach (v[i]) begin
      cyc(v[i].req, v[i].wr, v[i].strb, v[i].addr, v[i].wdata, v[i].hold);
      checks++; if (s_aok2 !== v[i].aok) begin failures++; $display("FAIL write_read_aok cyc=%0d got=%b exp=%b", i, s_aok2, v[i].aok); end
      checks++; if (s_dok2 !== v[i].dok) begin failures++; $display("FAIL write_read_dok cyc=%0d got=%b exp=%b", i, s_dok2, v[i].dok); end
      checks++; if (s_rd2 !== v[i].rd) begin failures++; $display("FAIL write_read_rd cyc=%0d got=%h exp=%h", i, s_rd2, v[i].rd); end
    end
  endtask

  // Three reads with req held: the third stalls until the first response frees a slot.
  task automatic test_qdepth_limit();
    vec_t v[7];
    v[0] = mk(1, 0, 4'h0, A, 32'h0, 0, 1, 0, 32'h0);
    v[1] = mk(1, 0, 4'h0, A, 32'h0, 0, 1, 0, 32'h0);
    v[2] = mk(1, 0, 4'h0, A, 32'h0, 0, 0, 1, 32'h1234_AB78);
    v[3] = mk(1, 0, 4'h0, A, 32'h0, 0, 1, 1, 32'h1234_AB78);
    v[4] = mk(0, 0, 4'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    v[5] = mk(0, 0, 4'h0, 0, 32'h0, 0, 1, 1, 32'h1234_AB78);
    v[6] = mk(0, 0, 4'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    foreach (v[i]) begin
      cyc(v[i].req, v[i].wr, v[i].strb, v[i].addr, v[i].wdata, v[i].hold);
      checks++; if (s_aok2 !== v[i].aok) begin failures++; $display("FAIL qdepth_aok cyc=%0d got=%b exp=%b", i, s_aok2, v[i].aok); end
      checks++; if (s_dok2 !== v[i].dok) begin failures++; $display("FAIL qdepth_dok cyc=%0d got=%b exp=%b", i, s_dok2, v[i].dok); end
      checks++; if (s_rd2 !== v[i].rd) begin failures++; $display("FAIL qdepth_rd cyc=%0d got=%h exp=%h", i, s_rd2, v[i].rd); end
    end
  endtask

  // Writes blocked by hold must never land in the array.
  task automatic test_hold();
    vec_t v[7];
    v[0] = mk(1, 1, 4'hF, A, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    v[1] = mk(1, 1, 4'hF, A, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    v[2] = mk(1, 1, 4'hF, A, 32'hDEAD_BEEF, 1, 0, 0, 32'h0);
    v[3] = mk(1, 0, 4'h0, A, 32'h0,         0, 1, 0, 32'h0);
    v[4] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    v[5] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 1, 32'h1234_AB78);
    v[6] = mk(0, 0, 4'h0, 0, 32'h0,         0, 1, 0, 32'h0);
    foreach (v[i]) begin
      cyc(v[i].req, v[i].wr, v[i].strb, v[i].addr, v[i].wdata, v[i].hold);
      checks++; if (s_aok2 !== v[i].aok) begin failures++; $display("FAIL hold_aok cyc=%0d got=%b exp=%b", i, s_aok2, v[i].aok); end
      checks++; if (s_dok2 !== v[i].dok) begin failures++; $display("FAIL hold_dok cyc=%0d got=%b exp=%b", i, s_dok2, v[i].dok); end
      checks++; if (s_rd2 !== v[i].rd) begin failures++; $display("FAIL hold_rd cyc=%0d got=%h exp=%h", i, s_rd2, v[i].rd); end
    end
  endtask

  // Reset with two reads in flight: their responses vanish, occupancy clears, array survives.
  task automatic test_reset_inflight();
    vec_t v[5];
    cyc(1'b1, 1'b0, 4'h0, A, 32'h0, 1'b0);
    checks++; if (s_aok2 !== 1'b1) begin failures++; $display("FAIL inflight_accept0 got=%b exp=1", s_aok2); end
    cyc(1'b1, 1'b0, 4'h0, A, 32'h0, 1'b0);
    checks++; if (s_aok2 !== 1'b1) begin failures++; $display("FAIL inflight_accept1 got=%b exp=1", s_aok2); end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (s_dok2 !== 1'b0) begin failures++; $display("FAIL inflight_dok_in_reset got=%b exp=0", s_dok2); end
    checks++; if (s_aok2 !== 1'b0) begin failures++; $display("FAIL inflight_aok_in_reset got=%b exp=0", s_aok2); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      checks++; if (s_dok2 !== 1'b0) begin failures++; $display("FAIL inflight_stale_dok cyc=%0d got=%b exp=0", i, s_dok2); end
      checks++; if (s_aok2 !== 1'b1) begin failures++; $display("FAIL inflight_post_aok cyc=%0d got=%b exp=1", i, s_aok2); end
    end
    v[0] = mk(1, 0, 4'h0, A, 32'h0, 0, 1, 0, 32'h0);
    v[1] = mk(1, 0, 4'h0, A, 32'h0, 0, 1, 0, 32'h0);
    v[2] = mk(0, 0, 4'h0, 0, 32'h0, 0, 0, 1, 32'h1234_AB78);
    v[3] = mk(0, 0, 4'h0, 0, 32'h0, 0, 1, 1, 32'h1234_AB78);
    v[4] = mk(0, 0, 4'h0, 0, 32'h0, 0, 1, 0, 32'h0);
    foreach (v[i]) begin
      cyc(v[i].req, v[i].wr, v[i].strb, v[i].addr, v[i].wdata, v[i].hold);
      checks++; if (s_aok2 !== v[i].aok) begin failures++; $display("FAIL after_reset_aok cyc=%0d got=%b exp=%b", i, s_aok2, v[i].aok); end
      checks++; if (s_dok2 !== v[i].dok) begin failures++; $display("FAIL after_reset_dok cyc=%0d got=%b exp=%b", i, s_dok2, v[i].dok); end
      checks++; if (s_rd2 !== v[i].rd) begin failures++; $display("FAIL after_reset_rd cyc=%0d got=%h exp=%h", i, s_rd2, v[i].rd); end
    end
  endtask

  // LATENCY=1: alternating write/read pairs to distinct words stream with no stalls.
  task automatic test_back_to_back();
    logic        r, w;
    logic [31:0] a, d, e_rd;
    logic        e_dok;
    int          k;
    for (int c = 0; c < 18; c++) begin
      r = 1'b0; w = 1'b0; a = 32'h0; d = 32'h0;
      if (c < 16) begin
        k = c / 2;
        r = 1'b1;
        w = ((c % 2) == 0);
        a = 32'h0000_0100 + 32'(k * 4);
        d = w ? (32'hC0DE_0000 + 32'(k)) : 32'h0;
      end
      e_dok = (c >= 1) && (c <= 16);
      e_rd  = (e_dok && ((c - 1) % 2 == 1)) ? (32'hC0DE_0000 + 32'((c - 1) / 2)) : 32'h0;
      cyc(r, w, 4'hF, a, d, 1'b0);
      checks++; if (s_aok1 !== 1'b1) begin failures++; $display("FAIL b2b_aok cyc=%0d got=%b exp=1", c, s_aok1); end
      checks++; if (s_dok1 !== e_dok) begin failures++; $display("FAIL b2b_dok cyc=%0d got=%b exp=%b", c, s_dok1, e_dok); end
      checks++; if (s_rd1 !== e_rd) begin failures++; $display("FAIL b2b_rd cyc=%0d got=%h exp=%h", c, s_rd1, e_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_qdepth_limit();
    test_hold();
    test_reset_inflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
